// File: rtl/mc_control_if.sv
// Bus between the multicycle control sequencer and the MIPS16 datapath:
// instruction fetch handshake, ALU select/compare, register-file,
// data-memory and PC strobes.
interface mc_control_if;
  logic        instr_req;
  logic        instr_valid;
  logic [15:0] instr;
  logic        branch_enable;
  logic        mem_ack;
  logic [3:0]  alu_sel;
  logic        alu_src_imm;
  logic [2:0]  rs_addr;
  logic [2:0]  rt_addr;
  logic [15:0] imm_ext;
  logic [2:0]  rf_waddr;
  logic        rf_we;
  logic        rf_wsel;
  logic        mem_req;
  logic        mem_we;
  logic        pc_we;
  logic        pc_src;
  logic        illegal_op;
  logic        halted;

  modport master (
    input  instr_valid, instr, branch_enable, mem_ack,
    output instr_req, alu_sel, alu_src_imm, rs_addr, rt_addr, imm_ext,
           rf_waddr, rf_we, rf_wsel, mem_req, mem_we, pc_we, pc_src,
           illegal_op, halted
  );

  modport slave (
    output instr_valid, instr, branch_enable, mem_ack,
    input  instr_req, alu_sel, alu_src_imm, rs_addr, rt_addr, imm_ext,
           rf_waddr, rf_we, rf_wsel, mem_req, mem_we, pc_we, pc_src,
           illegal_op, halted
  );
endinterface

// File: rtl/mc_control.sv
// Multicycle control sequencer for the MIPS16 datapath. Fetches an
// instruction, decodes its opcode into the ALU select code and walks it
// through EXECUTE / MEM / WB, issuing exactly one PC update per retired
// non-halt instruction. mul/div hold EXECUTE for MULDIV_CYCLES cycles.
module mc_control #(
  parameter int MULDIV_CYCLES = 1
) (
  input logic          clk,
  input logic          rst,
  mc_control_if.master bus
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    HALT    = 3'd5
  } state_t;

  localparam logic [3:0] MULDIV_LOAD = 4'(MULDIV_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] ir;
  logic [3:0]  cnt;
  logic        cnt_done;
  logic [3:0]  op;

  logic        is_rtype;
  logic        is_muldiv;
  logic        is_beq;
  logic        is_slti;
  logic        is_addi;
  logic        is_lw;
  logic        is_sw;
  logic        is_halt;
  logic        is_illegal;
  logic [3:0]  sel_dec;
  logic        src_imm_dec;

  assign op         = ir[15:12];
  assign cnt_done   = (cnt == 4'd0);
  assign is_rtype   = (op <= 4'h6);
  assign is_muldiv  = (op == 4'h2) || (op == 4'h3);
  assign is_beq     = (op == 4'h8);
  assign is_slti    = (op == 4'h9);
  assign is_addi    = (op == 4'hA);
  assign is_lw      = (op == 4'hB);
  assign is_sw      = (op == 4'hC);
  assign is_halt    = (op == 4'hF);
  assign is_illegal = (op == 4'h7) || (op == 4'hD) || (op == 4'hE);

  // Register-file addressing and immediate come straight from the held ir.
  assign bus.rs_addr  = ir[11:9];
  assign bus.rt_addr  = ir[8:6];
  assign bus.imm_ext  = {{10{ir[5]}}, ir[5:0]};
  assign bus.rf_waddr = is_rtype ? ir[5:3] : ir[8:6];

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Instruction register only loads on the FETCH handshake.
  always_ff @(posedge clk) begin
    if (rst)                                  ir <= 16'h0000;
    else if (state == FETCH && bus.instr_valid) ir <= bus.instr;
  end

  // EXECUTE cycle counter: loaded on the way into EXECUTE, counts down to zero.
  always_ff @(posedge clk) begin
    if (rst)                               cnt <= 4'd0;
    else if (state == DECODE)              cnt <= is_muldiv ? MULDIV_LOAD : 4'd0;
    else if (state == EXECUTE && !cnt_done) cnt <= cnt - 4'd1;
  end

  // Opcode to ALU select / operand source; halt and illegal opcodes select nothing.
  always_comb begin
    sel_dec     = 4'b0000;
    src_imm_dec = 1'b0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: sel_dec = op;
      4'h8: sel_dec = 4'b1000;
      4'h9: begin
        sel_dec     = 4'b1001;
        src_imm_dec = 1'b1;
      end
      4'hA, 4'hB, 4'hC: begin
        sel_dec     = 4'b1010;
        src_imm_dec = 1'b1;
      end
      default: sel_dec = 4'b0000;
    endcase
  end

  // Next-state sequencing.
  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (bus.instr_valid) state_next = DECODE;
      DECODE:  state_next = EXECUTE;
      EXECUTE: begin
        if (cnt_done) begin
          if (is_rtype || is_slti || is_addi) state_next = WB;
          else if (is_lw || is_sw)            state_next = MEM;
          else if (is_halt)                   state_next = HALT;
          else                                state_next = FETCH;
        end
      end
      MEM:     if (bus.mem_ack) state_next = is_sw ? FETCH : WB;
      WB:      state_next = FETCH;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // Output decode; every strobe and the ALU select are forced low during reset.
  always_comb begin
    bus.instr_req   = 1'b0;
    bus.alu_sel     = 4'b0000;
    bus.alu_src_imm = 1'b0;
    bus.rf_we       = 1'b0;
    bus.rf_wsel     = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.pc_we       = 1'b0;
    bus.pc_src      = 1'b0;
    bus.illegal_op  = 1'b0;
    bus.halted      = 1'b0;
    case (state)
      FETCH: bus.instr_req = 1'b1;
      DECODE: begin
        bus.alu_sel     = sel_dec;
        bus.alu_src_imm = src_imm_dec;
      end
      EXECUTE: begin
        bus.alu_sel     = sel_dec;
        bus.alu_src_imm = src_imm_dec;
        if (cnt_done && is_beq) begin
          bus.pc_we  = 1'b1;
          bus.pc_src = bus.branch_enable;
        end
        if (cnt_done && is_illegal) begin
          bus.pc_we      = 1'b1;
          bus.illegal_op = 1'b1;
        end
      end
      MEM: begin
        bus.alu_sel     = sel_dec;
        bus.alu_src_imm = src_imm_dec;
        bus.mem_req     = 1'b1;
        bus.mem_we      = is_sw;
        bus.pc_we       = is_sw && bus.mem_ack;
      end
      WB: begin
        bus.alu_sel     = sel_dec;
        bus.alu_src_imm = src_imm_dec;
        bus.rf_we       = 1'b1;
        bus.rf_wsel     = is_lw;
        bus.pc_we       = 1'b1;
      end
      HALT:    bus.halted = 1'b1;
      default: bus.instr_req = 1'b0;
    endcase
    if (rst) begin
      bus.alu_sel     = 4'b0000;
      bus.alu_src_imm = 1'b0;
      bus.rf_we       = 1'b0;
      bus.rf_wsel     = 1'b0;
      bus.mem_req     = 1'b0;
      bus.mem_we      = 1'b0;
      bus.pc_we       = 1'b0;
      bus.pc_src      = 1'b0;
      bus.illegal_op  = 1'b0;
      bus.halted      = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control. Each instruction is expanded into its
// expected cycle-by-cycle trace from its instruction class, and every cycle
// the full packed output vector is compared against that trace.
module tb_mc_control;

  localparam int MD = 4;
  // Strobes, halted and ALU select/source: everything forced low in reset.
  localparam logic [38:0] RST_MASK = 39'h3E000000FF;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  logic [15:0] model_ir;

  always #5 clk = ~clk;

  mc_control_if bus();

  mc_control #(.MULDIV_CYCLES(MD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Bounded run time so a stuck bench still reports.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic rand1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [15:0] rand16();
    return 16'($urandom);
  endfunction

  // ALU select and operand source from the opcode table.
  function automatic logic [4:0] model_alu(input logic [3:0] op);
    if (op <= 4'h6)                          return {op, 1'b0};
    if (op == 4'h8)                          return {4'b1000, 1'b0};
    if (op == 4'h9)                          return {4'b1001, 1'b1};
    if (op == 4'hA || op == 4'hB || op == 4'hC) return {4'b1010, 1'b1};
    return 5'b0;
  endfunction

  function automatic logic [38:0] mk_vec(
    input logic req, input logic [3:0] sel, input logic src, input logic [15:0] irw,
    input logic rfwe, input logic wsel, input logic mreq, input logic mwe,
    input logic pcwe, input logic pcsrc, input logic ill, input logic hlt);
    logic [2:0]  waddr;
    logic [15:0] imm;
    waddr = (irw[15:12] <= 4'h6) ? irw[5:3] : irw[8:6];
    imm   = irw[5] ? (16'(irw[5:0]) - 16'd64) : 16'(irw[5:0]);
    return {req, sel, src, irw[11:9], irw[8:6], imm, waddr,
            rfwe, wsel, mreq, mwe, pcwe, pcsrc, ill, hlt};
  endfunction

  function automatic logic [38:0] dut_vec();
    return {bus.instr_req, bus.alu_sel, bus.alu_src_imm, bus.rs_addr, bus.rt_addr,
            bus.imm_ext, bus.rf_waddr, bus.rf_we, bus.rf_wsel, bus.mem_req,
            bus.mem_we, bus.pc_we, bus.pc_src, bus.illegal_op, bus.halted};
  endfunction

  task automatic checkOutput(input string tag, input logic [38:0] got, input logic [38:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (ir model %h)", tag, got, exp, model_ir);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] w, input logic be,
                               input logic ack, input logic r);
    bus.instr_valid   = v;
    bus.instr         = w;
    bus.branch_enable = be;
    bus.mem_ack       = ack;
    rst               = r;
  endtask

  task automatic check_cycle(input string tag, input logic [38:0] exp);
    #1;
    checkOutput(tag, dut_vec(), exp);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    applyStimulus(rand1(), rand16(), rand1(), 1'b1, 1'b1);
    #1;
    checkOutput(tag, dut_vec() & RST_MASK, 39'd0);
    @(negedge clk);
    model_ir = 16'h0000;
  endtask

  task automatic runInstr(input logic [15:0] word, input int fetch_wait, input int ack_delay,
                          input logic be, input logic abort_mem);
    logic [3:0] op;
    logic [3:0] sel;
    logic       src;
    logic       last;
    logic       is_beq;
    logic       is_ill;
    logic       is_sw;
    int         n;
    op     = word[15:12];
    {sel, src} = model_alu(op);
    n      = (op == 4'h2 || op == 4'h3) ? MD : 1;
    is_beq = (op == 4'h8);
    is_ill = (op == 4'h7 || op == 4'hD || op == 4'hE);
    is_sw  = (op == 4'hC);

    for (int i = 0; i < fetch_wait; i++) begin
      applyStimulus(1'b0, rand16(), rand1(), rand1(), 1'b0);
      check_cycle("fetch_wait", mk_vec(1, 4'h0, 0, model_ir, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    applyStimulus(1'b1, word, rand1(), rand1(), 1'b0);
    check_cycle("fetch", mk_vec(1, 4'h0, 0, model_ir, 0, 0, 0, 0, 0, 0, 0, 0));
    model_ir = word;

    applyStimulus(rand1(), rand16(), rand1(), rand1(), 1'b0);
    check_cycle("decode", mk_vec(0, sel, src, model_ir, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      applyStimulus(rand1(), rand16(), last ? be : rand1(), rand1(), 1'b0);
      check_cycle("execute", mk_vec(0, sel, src, model_ir, 0, 0, 0, 0,
                                    last && (is_beq || is_ill), last && is_beq && be,
                                    last && is_ill, 0));
    end

    if (op == 4'hF) begin
      for (int i = 0; i < 6; i++) begin
        applyStimulus(1'b1, rand16(), rand1(), rand1(), 1'b0);
        check_cycle("halt", mk_vec(0, 4'h0, 0, model_ir, 0, 0, 0, 0, 0, 0, 0, 1));
      end
      do_reset("halt_reset");
    end else if (op == 4'hB || is_sw) begin
      for (int i = 0; i < ack_delay; i++) begin
        applyStimulus(rand1(), rand16(), rand1(), 1'b0, 1'b0);
        check_cycle("mem_wait", mk_vec(0, sel, src, model_ir, 0, 0, 1, is_sw, 0, 0, 0, 0));
      end
      if (abort_mem) begin
        do_reset("mem_abort");
        return;
      end
      applyStimulus(rand1(), rand16(), rand1(), 1'b1, 1'b0);
      check_cycle("mem_ack", mk_vec(0, sel, src, model_ir, 0, 0, 1, is_sw, is_sw, 0, 0, 0));
      if (!is_sw) begin
        applyStimulus(rand1(), rand16(), rand1(), rand1(), 1'b0);
        check_cycle("wb_lw", mk_vec(0, sel, src, model_ir, 1, 1, 0, 0, 1, 0, 0, 0));
      end
    end else if (op <= 4'h6 || op == 4'h9 || op == 4'hA) begin
      applyStimulus(rand1(), rand16(), rand1(), rand1(), 1'b0);
      check_cycle("wb", mk_vec(0, sel, src, model_ir, 1, 0, 0, 0, 1, 0, 0, 0));
    end
  endtask

  initial begin
    logic [15:0] w;
    model_ir = 16'h0000;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    do_reset("reset");

    runInstr(16'h0298, 0, 0, 1'b0, 1'b0);  // add r3 = r1 + r2
    runInstr(16'hA2BF, 1, 0, 1'b0, 1'b0);  // addi r2 = r1 + (-1)
    runInstr(16'h8000, 0, 0, 1'b1, 1'b0);  // beq taken
    runInstr(16'h8000, 0, 0, 1'b0, 1'b0);  // beq not taken
    runInstr(16'hB283, 0, 3, 1'b0, 1'b0);  // lw, ack after 3 waits
    runInstr(16'hC283, 2, 1, 1'b0, 1'b0);  // sw
    runInstr(16'h3298, 0, 0, 1'b0, 1'b0);  // div, long EXECUTE
    runInstr(16'h7123, 0, 0, 1'b0, 1'b0);  // illegal opcode
    runInstr(16'hB1C5, 0, 2, 1'b0, 1'b1);  // lw aborted by reset in MEM
    runInstr(16'hC1C5, 1, 1, 1'b0, 1'b1);  // sw aborted by reset in MEM
    runInstr(16'h9A7E, 0, 0, 1'b0, 1'b0);  // slti
    runInstr(16'hF000, 0, 0, 1'b0, 1'b0);  // halt, then reset

    for (int k = 0; k < 80; k++) begin
      w = rand16();
      runInstr(w, $urandom_range(0, 2), $urandom_range(0, 3), rand1(),
               ($urandom_range(0, 4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
